fpmul_arbiter: RTL
==================

# fpmul_arbiter

Round-robin scheduler that shares one pipelined single-precision floating-point multiplier (`Floatingmul`-class unit, fixed latency, no stall) among several requesters in the compression datapath, e.g. DCT scaling and quantisation stages. It accepts one operand pair per cycle from a winning requester and registers the operands into the multiplier. It tracks each in-flight operation with a requester tag and returns the product, tagged with the originating requester, a fixed number of cycles later.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `LAT`, 3: multiplier latency in cycles from `mul_A`/`mul_B` applied to `mul_out` valid, 1..16.
- `IDW`, 2: requester-id width, must satisfy 2^IDW >= NREQ.

Ports:
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req_valid`, in, NREQ: per-requester operand-pair valid.
- `req_a`, in, 32*NREQ: operand A; requester i occupies bits [32i+31:32i].
- `req_b`, in, 32*NREQ: operand B, same packing as `req_a`.
- `req_ready`, out, NREQ: one-hot grant; combinational from `req_valid` and the priority pointer.
- `mul_A`, out, 32: registered operand A to the multiplier.
- `mul_B`, out, 32: registered operand B to the multiplier.
- `mul_out`, in, 32: multiplier product.
- `res_valid`, out, 1: registered result strobe, one cycle per result.
- `res_id`, out, IDW: requester index owning `res_data`.
- `res_data`, out, 32: registered product.
- `inflight`, out, IDW+5: count of issued operations whose results are not yet delivered.

## Operation
- Transfer on requester i occurs at an edge where `req_valid[i] & req_ready[i]`.
- Arbitration: priority pointer `ptr` (0..NREQ-1). Grant goes to the first i with `req_valid[i]` scanning ptr, ptr+1, … modulo NREQ. At most one `req_ready` bit is high. No valid requester means `req_ready`=0.
- On transfer from i: `mul_A`/`mul_B` <= operands of i, and `ptr` <= (i+1) mod NREQ. With no transfer, `ptr` holds and `mul_A`/`mul_B` hold their last value.
- Tag pipeline: a shift register of depth LAT+1 carries {valid, id}. Stage 0 loads {transfer, i} each cycle and the pipeline advances every cycle with no stall.
- At the output stage: `res_valid` <= tag valid, `res_id` <= tag id, `res_data` <= `mul_out`. `res_data` holds its value when no result is present.
- Results have no backpressure. Requesters must accept `res_valid` whenever it is asserted.
- Result order equals issue order. A single requester can issue every cycle.
- `inflight`: +1 on transfer, −1 on `res_valid`, both in the same cycle = unchanged. Maximum is LAT+1.
- Requester dropping `req_valid` without a transfer is permitted, and the grant moves on. Operands must be stable only in the transfer cycle.

## Timing
- Reset values: `ptr`=0, all tag valids 0, `mul_A`=`mul_B`=0, `res_valid`=0, `res_id`=0, `res_data`=0, `inflight`=0. While `rst` is high, `req_ready`=0.
- Transfer at edge t leads to `mul_A`/`mul_B` valid during cycle t+1, `mul_out` valid during cycle t+1+LAT, and `res_valid` high during cycle t+2+LAT. Total latency is LAT+2 edges.
- Throughput is 1 operation/cycle aggregate. Under persistent all-valid requests each requester gets exactly 1 grant per NREQ cycles.
- Reset mid-operation: all in-flight operations are discarded and no stale `res_valid` appears after deassertion. The first grant after reset goes to the lowest-index valid requester.
- Simultaneous transfer and result delivery in the same cycle are both handled, and `inflight` is unchanged.
- Pointer wrap: a grant to NREQ-1 sets `ptr`=0.

## Test plan
- Single op: NREQ=4, LAT=3, requester 2 sends A=0x3FC00000 (1.5) and B=0x40000000 (2.0) with a behavioural multiplier model. Expect `res_valid` exactly 5 edges after transfer, `res_id`=2, `res_data`=0x40400000, and `inflight` 1→0.
- Fairness: all 4 requesters hold valid for 16 cycles. Expect grants in order 0,1,2,3,0,… with 4 grants each, no idle cycle, and results returned in the same id order.
- Pointer skip/wrap: only requesters 1 and 3 valid, `ptr`=0. Expect grants 1,3,1,3. Then after a grant to 3, requester 0 alone is valid and is granted next cycle.
- Back-to-back single requester: requester 0 issues 8 consecutive pairs (k·1.0 × 2.0, k=1..8). Expect 8 consecutive `res_valid` cycles with 2k in order and `inflight` peaking at LAT+1=4.
- Reset mid-flight: issue 3 ops, assert `rst` asynchronously between edges before any result. Expect all outputs at reset values immediately, no `res_valid` for 10 cycles after release, and `ptr`=0 behaviour.
- Idle/drop: requester raises `req_valid` for a cycle in which another requester holds the grant and then drops it. Expect no transfer for it, no `res_valid` with its id, and `mul_A`/`mul_B` unchanged when no transfer occurs.

Source files
------------

// File: rtl/fpmul_arbiter_if.sv
// Requester / multiplier / result bundle for the shared FP multiplier arbiter.
interface fpmul_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic [31:0]          mul_A;
  logic [31:0]          mul_B;
  logic [31:0]          mul_out;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic [31:0]          res_data;
  logic [IDW+4:0]       inflight;

  // Requester side plus the multiplier product feeding back in.
  modport master (
    output req_valid, req_a, req_b, mul_out,
    input  req_ready, mul_A, mul_B, res_valid, res_id, res_data, inflight
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, mul_out,
    output req_ready, mul_A, mul_B, res_valid, res_id, res_data, inflight
  );
endinterface

// File: rtl/fpmul_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined FP multiplier among NREQ requesters.
// Each issued operand pair carries a requester tag down a no-stall pipeline so the
// product comes back labelled with its owner, in issue order.
module fpmul_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 3,
  parameter int unsigned IDW  = 2
) (
  input  logic           clk,
  input  logic           rst,
  fpmul_arbiter_if.slave io_bus
);

  localparam int unsigned CntW = IDW + 5;

  // State
  logic [IDW-1:0]  r_ptr;
  logic [31:0]     r_mul_a;
  logic [31:0]     r_mul_b;
  logic            r_tag_v  [LAT+1];
  logic [IDW-1:0]  r_tag_id [LAT+1];
  logic            r_res_valid;
  logic [IDW-1:0]  r_res_id;
  logic [31:0]     r_res_data;
  logic [CntW-1:0] r_inflight;

  // Combinational
  logic            w_xfer;
  logic [IDW-1:0]  w_gnt_id;
  logic [NREQ-1:0] w_grant;
  logic [31:0]     w_op_a;
  logic [31:0]     w_op_b;
  logic [IDW-1:0]  w_ptr_d;
  logic [CntW-1:0] w_inflight_d;
  int unsigned     w_dist;
  int unsigned     w_best;

  // Pick the valid requester closest to ptr going upward (mod NREQ); none while in reset.
  always_comb begin
    w_xfer   = 1'b0;
    w_gnt_id = '0;
    w_best   = NREQ;
    w_dist   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_dist = (i + NREQ - 32'(r_ptr)) % NREQ;
      if (io_bus.req_valid[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        w_gnt_id = IDW'(i);
        w_xfer   = 1'b1;
      end
    end
    if (rst) begin
      w_xfer = 1'b0;
    end
  end

  // One-hot grant and operand select for the winner.
  always_comb begin
    w_grant = '0;
    w_op_a  = '0;
    w_op_b  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_xfer && (w_gnt_id == IDW'(i))) begin
        w_grant[i] = 1'b1;
        w_op_a     = io_bus.req_a[32*i +: 32];
        w_op_b     = io_bus.req_b[32*i +: 32];
      end
    end
  end

  // Next pointer is one past the winner, wrapping at NREQ-1.
  always_comb begin
    w_ptr_d = r_ptr;
    if (w_xfer) begin
      w_ptr_d = (32'(w_gnt_id) == NREQ - 1) ? '0 : w_gnt_id + IDW'(1);
    end
  end

  // Issue adds one, a tag leaving the last stage (result being captured) removes one.
  always_comb begin
    w_inflight_d = r_inflight;
    if (w_xfer && !r_tag_v[LAT]) begin
      w_inflight_d = r_inflight + CntW'(1);
    end else if (!w_xfer && r_tag_v[LAT]) begin
      w_inflight_d = r_inflight - CntW'(1);
    end
  end

  // Pointer and multiplier operand registers; operands hold when nothing is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else begin
      r_ptr <= w_ptr_d;
      if (w_xfer) begin
        r_mul_a <= w_op_a;
        r_mul_b <= w_op_b;
      end
    end
  end

  // Tag pipeline: stage LAT lines up with the cycle mul_out carries that operation's product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i <= LAT; i++) begin
        r_tag_v[i]  <= 1'b0;
        r_tag_id[i] <= '0;
      end
    end else begin
      r_tag_v[0]  <= w_xfer;
      r_tag_id[0] <= w_gnt_id;
      for (int unsigned i = 1; i <= LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  // Result capture; id and data hold between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_data  <= '0;
    end else begin
      r_res_valid <= r_tag_v[LAT];
      if (r_tag_v[LAT]) begin
        r_res_id   <= r_tag_id[LAT];
        r_res_data <= io_bus.mul_out;
      end
    end
  end

  // Outstanding-operation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= w_inflight_d;
    end
  end

  assign io_bus.req_ready = w_grant;
  assign io_bus.mul_A     = r_mul_a;
  assign io_bus.mul_B     = r_mul_b;
  assign io_bus.res_valid = r_res_valid;
  assign io_bus.res_id    = r_res_id;
  assign io_bus.res_data  = r_res_data;
  assign io_bus.inflight  = r_inflight;

endmodule
